lbc_lbus_arb: RTL and testbench
===============================

LBC_LBUS_ARB -- requirements
Module: lbc_lbus_arb

Interface
REQ-001 Parameter: GNT_TIMEOUT, default 8, number of cycles a grant waits for LBUS_FRAME before it is revoked; legal range 2..255.
REQ-002 BUSCLK  input  1  clock; all state changes on the rising edge.
REQ-003 RESET_LR_N  input  1  reset, asynchronous, active-low.
REQ-004 LA_REQ  input  4  bus requests from local masters, bit i = master i, level-sensitive.
REQ-005 LA_ENABLE  input  1  arbitration enable; low = no new grants.
REQ-006 LBUS_FRAME  input  1  bus FRAME, active-high.
REQ-007 LBUS_IRDY  input  1  bus IRDY, active-high.
REQ-008 LBUS_ABORT  input  1  bus abort, active-high.
REQ-009 LA_GNT_LR  output  4  registered grants, one-hot or zero.
REQ-010 LA_OWNER_LR  output  2  index of the current or most recent owner.
REQ-011 LA_BUSY_LR  output  1  high while the FSM is in any state other than IDLE.
REQ-012 LA_TIMEOUT_LR  output  1  one-cycle pulse on grant revocation by timeout.

Function
REQ-013 FSM, one-hot, states: IDLE, GRANT, BUSY, TURN.
REQ-014 Bus idle = !LBUS_FRAME & !LBUS_IRDY, sampled in the current cycle.
REQ-015 IDLE: if LA_ENABLE, |LA_REQ and bus idle, the FSM shall select the winner, go to GRANT, and assert LA_GNT_LR[winner] on the next edge; otherwise it stays in IDLE with grants at zero.
REQ-016 Winner: round-robin; the first requesting index after LA_OWNER_LR, searched modulo 4 in ascending order.
REQ-017 LA_OWNER_LR shall update to the winner on the same edge the grant asserts, and shall hold at all other times.
REQ-018 GRANT: the timeout counter is cleared on entry and increments every cycle.
REQ-019 GRANT: LBUS_FRAME high -> BUSY, grant held.
REQ-020 GRANT: LA_REQ[owner] low before FRAME -> IDLE, grant cleared, no timeout pulse.
REQ-021 GRANT: counter == GNT_TIMEOUT-1 with no FRAME -> IDLE, grant cleared, LA_TIMEOUT_LR pulses one cycle.
REQ-022 GRANT: FRAME and timeout in the same cycle -> FRAME wins.
REQ-023 BUSY, grant retention: LA_GNT_LR[owner] stays high while LA_REQ[owner] is high and no other LA_REQ bit is set (back-to-back transfers).
REQ-024 BUSY, grant removal: the grant is cleared on the edge after any other request, or after the owner's request drops; once cleared it is not reasserted in BUSY.
REQ-025 BUSY: bus idle -> TURN.
REQ-026 TURN: lasts exactly one cycle with grants at zero, then -> IDLE; re-arbitration from IDLE happens at the earliest on the following edge.
REQ-027 LBUS_ABORT high in GRANT or BUSY -> TURN, grants cleared on that edge; LBUS_ABORT in IDLE or TURN has no effect.
REQ-028 LA_ENABLE low does not revoke a grant already given; it only blocks the IDLE->GRANT transition.
REQ-029 At most one LA_GNT_LR bit is high in any cycle.
REQ-030 No grant is asserted while the bus is non-idle, except retention per REQ-023.
REQ-031 The timeout counter is 8 bits; it saturates and never wraps.

Reset
REQ-032 While RESET_LR_N is low: FSM=IDLE, LA_GNT_LR=0, LA_OWNER_LR=3 (so master 0 has first priority), LA_BUSY_LR=0, LA_TIMEOUT_LR=0, counter=0.
REQ-033 Reset asserted mid-transaction clears the grant immediately (asynchronously).
REQ-034 After reset deasserts, arbitration resumes from IDLE at the first edge.

Verification
REQ-035 Reset, then LA_REQ=4'b1010 with bus idle -> LA_GNT_LR=4'b0010 one cycle later, LA_OWNER_LR=1.
REQ-036 Fairness: all four requests held, each master asserts FRAME for 2 cycles on its grant -> grant order 0,1,2,3,0, with one TURN cycle between each grant.
REQ-037 Timeout: GNT_TIMEOUT=8, master 2 granted and never asserts FRAME -> grant drops after 8 cycles in GRANT, LA_TIMEOUT_LR pulses once, next winner is master 3 if requesting.
REQ-038 Back-to-back: master 0 alone requests through three FRAME bursts -> LA_GNT_LR stays 4'b0001 throughout BUSY; master 1 then requests -> grant drops on the next edge, master 1 granted after the bus goes idle plus TURN.
REQ-039 Abort and reset: LBUS_ABORT in BUSY -> grants 0 next edge, TURN, IDLE; RESET_LR_N pulsed low in GRANT -> LA_GNT_LR=0 immediately, LA_OWNER_LR=3.

Source files
------------

// File: rtl/lbc_lbus_arb.sv
// lbc_lbus_arb: round-robin local-bus arbiter for four masters, with a grant
// timeout, back-to-back grant retention and a one-cycle turnaround after each tenure.
module lbc_lbus_arb #(
    parameter int GNT_TIMEOUT = 8
) (
    input  logic       BUSCLK,
    input  logic       RESET_LR_N,
    input  logic [3:0] LA_REQ,
    input  logic       LA_ENABLE,
    input  logic       LBUS_FRAME,
    input  logic       LBUS_IRDY,
    input  logic       LBUS_ABORT,
    output logic [3:0] LA_GNT_LR,
    output logic [1:0] LA_OWNER_LR,
    output logic       LA_BUSY_LR,
    output logic       LA_TIMEOUT_LR
);
    localparam logic [3:0] IDLE = 4'b0001, GRANT = 4'b0010, BUSY = 4'b0100, TURN = 4'b1000;
    localparam logic [7:0] T_LAST = 8'(GNT_TIMEOUT - 1);

    logic [3:0] state, state_nxt, gnt_nxt, own_mask;
    logic [1:0] owner_nxt, win;
    logic [7:0] cnt, cnt_nxt;
    logic       tmo_nxt, bus_idle, found;

    assign bus_idle = !LBUS_FRAME && !LBUS_IRDY;
    assign own_mask = 4'(1) << LA_OWNER_LR;

    always_ff @(posedge BUSCLK or negedge RESET_LR_N) begin
        if (!RESET_LR_N) begin
            state         <= IDLE;
            LA_GNT_LR     <= '0;
            LA_OWNER_LR   <= 2'd3;
            LA_TIMEOUT_LR <= 1'b0;
            cnt           <= '0;
        end else begin
            state         <= state_nxt;
            LA_GNT_LR     <= gnt_nxt;
            LA_OWNER_LR   <= owner_nxt;
            LA_TIMEOUT_LR <= tmo_nxt;
            cnt           <= cnt_nxt;
        end
    end

    // First requester after the current owner, ascending modulo 4
    always_comb begin
        win   = LA_OWNER_LR;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && LA_REQ[LA_OWNER_LR + 2'(k)]) begin
                win   = LA_OWNER_LR + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = LA_GNT_LR;
        owner_nxt = LA_OWNER_LR;
        cnt_nxt   = (cnt == 8'hff) ? cnt : cnt + 8'd1;
        tmo_nxt   = 1'b0;
        if (state[0]) begin
            gnt_nxt = '0;
            cnt_nxt = '0;
            if (LA_ENABLE && |LA_REQ && bus_idle) begin
                state_nxt = GRANT;
                gnt_nxt   = 4'(1) << win;
                owner_nxt = win;
            end
        end else if (state[1]) begin
            if (LBUS_ABORT) begin
                state_nxt = TURN;
                gnt_nxt   = '0;
            end else if (LBUS_FRAME) begin
                state_nxt = BUSY;
            end else if (!LA_REQ[LA_OWNER_LR] || cnt == T_LAST) begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                tmo_nxt   = LA_REQ[LA_OWNER_LR];
            end
        end else if (state[2]) begin
            if (LBUS_ABORT || bus_idle) begin
                state_nxt = TURN;
                gnt_nxt   = '0;
            end else if (|(LA_REQ & ~own_mask) || !LA_REQ[LA_OWNER_LR]) begin
                gnt_nxt = '0;
            end
        end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
        end
    end

    always_comb begin
        LA_BUSY_LR = !state[0];
    end
endmodule

// File: tb/tb_lbc_lbus_arb.sv
// tb_lbc_lbus_arb: directed checks of arbitration order, timeout, retention,
// abort and asynchronous reset for lbc_lbus_arb with GNT_TIMEOUT = 8.
module tb_lbc_lbus_arb;
    logic       BUSCLK = 0, RESET_LR_N = 0, LA_ENABLE = 0;
    logic       LBUS_FRAME = 0, LBUS_IRDY = 0, LBUS_ABORT = 0;
    logic [3:0] LA_REQ = 0;
    logic [3:0] LA_GNT_LR;
    logic [1:0] LA_OWNER_LR;
    logic       LA_BUSY_LR, LA_TIMEOUT_LR;
    int         n_chk = 0, n_fail = 0;

    lbc_lbus_arb #(.GNT_TIMEOUT(8)) dut (
        .BUSCLK(BUSCLK), .RESET_LR_N(RESET_LR_N), .LA_REQ(LA_REQ), .LA_ENABLE(LA_ENABLE),
        .LBUS_FRAME(LBUS_FRAME), .LBUS_IRDY(LBUS_IRDY), .LBUS_ABORT(LBUS_ABORT),
        .LA_GNT_LR(LA_GNT_LR), .LA_OWNER_LR(LA_OWNER_LR), .LA_BUSY_LR(LA_BUSY_LR),
        .LA_TIMEOUT_LR(LA_TIMEOUT_LR)
    );

    always #5 BUSCLK = ~BUSCLK;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge BUSCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic t);
        chk({tag, ".gnt"}, 8'(LA_GNT_LR), 8'(g));
        chk({tag, ".owner"}, 8'(LA_OWNER_LR), 8'(o));
        chk({tag, ".busy"}, 8'(LA_BUSY_LR), 8'(b));
        chk({tag, ".tmo"}, 8'(LA_TIMEOUT_LR), 8'(t));
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        tick(2);
        chk_state("reset", 4'b0000, 2'd3, 0, 0);
        RESET_LR_N = 1;
        LA_ENABLE  = 1;
        LA_REQ     = 4'b1010;
        tick();
        chk_state("first_grant", 4'b0010, 2'd1, 1, 0);
        LA_REQ = 4'b0000;
        tick();
        chk_state("req_drop", 4'b0000, 2'd1, 0, 0);
        RESET_LR_N = 0;
        #1;
        chk_state("reset_idle", 4'b0000, 2'd3, 0, 0);
        RESET_LR_N = 1;
        LA_REQ = 4'b1111;
        foreach (order[i]) begin
            tick();
            chk_state($sformatf("fair%0d.grant", i), 4'(1) << order[i], 2'(order[i]), 1, 0);
            LBUS_FRAME = 1;
            tick();
            chk($sformatf("fair%0d.hold", i), 8'(LA_GNT_LR), 8'(4'(1) << order[i]));
            tick();
            chk($sformatf("fair%0d.yield", i), 8'(LA_GNT_LR), 8'h00);
            LBUS_FRAME = 0;
            tick();
            chk_state($sformatf("fair%0d.turn", i), 4'b0000, 2'(order[i]), 1, 0);
            tick();
            chk_state($sformatf("fair%0d.idle", i), 4'b0000, 2'(order[i]), 0, 0);
        end
        LA_REQ = 4'b1100;
        tick();
        chk_state("tmo.grant", 4'b0100, 2'd2, 1, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_state($sformatf("tmo.wait%0d", i), 4'b0100, 2'd2, 1, 0);
        end
        tick();
        chk_state("tmo.revoke", 4'b0000, 2'd2, 0, 1);
        tick();
        chk_state("tmo.next", 4'b1000, 2'd3, 1, 0);
        LA_REQ = 4'b0000;
        tick();
        chk_state("tmo.release", 4'b0000, 2'd3, 0, 0);
        LA_REQ = 4'b0001;
        tick();
        chk_state("b2b.grant", 4'b0001, 2'd0, 1, 0);
        for (int b = 0; b < 3; b++) begin
            LBUS_FRAME = 1;
            LBUS_IRDY  = 1;
            tick();
            chk($sformatf("b2b%0d.a", b), 8'(LA_GNT_LR), 8'h01);
            tick();
            chk($sformatf("b2b%0d.b", b), 8'(LA_GNT_LR), 8'h01);
            LBUS_FRAME = 0;
            tick();
            chk($sformatf("b2b%0d.c", b), 8'(LA_GNT_LR), 8'h01);
        end
        LA_REQ = 4'b0011;
        tick();
        chk_state("b2b.drop", 4'b0000, 2'd0, 1, 0);
        tick();
        chk_state("b2b.stay_off", 4'b0000, 2'd0, 1, 0);
        LBUS_IRDY = 0;
        tick();
        chk_state("b2b.turn", 4'b0000, 2'd0, 1, 0);
        tick();
        chk_state("b2b.idle", 4'b0000, 2'd0, 0, 0);
        tick();
        chk_state("b2b.m1", 4'b0010, 2'd1, 1, 0);
        LA_REQ     = 4'b0010;
        LBUS_FRAME = 1;
        tick();
        chk_state("abort.busy", 4'b0010, 2'd1, 1, 0);
        LBUS_ABORT = 1;
        tick();
        chk_state("abort.turn", 4'b0000, 2'd1, 1, 0);
        LBUS_ABORT = 0;
        LBUS_FRAME = 0;
        tick();
        chk_state("abort.idle", 4'b0000, 2'd1, 0, 0);
        tick();
        chk_state("abort.regrant", 4'b0010, 2'd1, 1, 0);
        RESET_LR_N = 0;
        #1;
        chk_state("async_reset", 4'b0000, 2'd3, 0, 0);
        RESET_LR_N = 1;
        LA_ENABLE  = 0;
        tick();
        chk_state("en_low.block", 4'b0000, 2'd3, 0, 0);
        LA_ENABLE = 1;
        tick();
        chk_state("en.grant", 4'b0010, 2'd1, 1, 0);
        LA_ENABLE = 0;
        tick();
        chk_state("en_low.keep", 4'b0010, 2'd1, 1, 0);
        LA_REQ    = 4'b0000;
        LA_ENABLE = 1;
        tick();
        chk_state("en.release", 4'b0000, 2'd1, 0, 0);
        LA_REQ     = 4'b0001;
        LBUS_FRAME = 1;
        tick();
        chk_state("busy_bus.nogrant", 4'b0000, 2'd1, 0, 0);
        LBUS_FRAME = 0;
        tick();
        chk_state("busy_bus.grant", 4'b0001, 2'd0, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
